// File: rtl/vrf_pkg.sv
// Shared geometry for the vector register file and its write arbiter.
// Holds the default vrf dimensions and the address-field widths derived from
// them, so the arbiter, the vrf and any bench agree on one set of numbers.
package vrf_pkg;

  localparam int def_els_p   = 32;  // total vector registers
  localparam int def_vlen_p  = 8;   // elements per vector
  localparam int def_vdw_p   = 32;  // bits per element
  localparam int def_lanes_p = 4;   // vrf lanes (power of two)
  localparam int def_reqs_p  = 3;   // producers sharing the write ports

  // Global register number = {lane, lane-local address}.
  localparam int def_lane_w  = $clog2(def_lanes_p);
  localparam int def_laddr_w = $clog2(def_els_p / def_lanes_p);
  localparam int def_gaddr_w = def_lane_w + def_laddr_w;
  localparam int def_data_w  = def_vlen_p * def_vdw_p;

endpackage

// File: rtl/vrf_lane_rr_arb.sv
// Round-robin arbiter for one vrf write lane.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   cand_i         : requesters currently asking for this lane
//   grant_o        : one-hot winner (combinational), zero when no candidate
// The pointer names the requester with highest priority this cycle; after a
// grant it moves to the requester just past the winner.
module vrf_lane_rr_arb
  import vrf_pkg::*;
#(
  parameter int reqs_p = def_reqs_p,
  localparam int ptr_w = (reqs_p > 1) ? $clog2(reqs_p) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [reqs_p-1:0] cand_i,
  output logic [reqs_p-1:0] grant_o
);

  logic [ptr_w-1:0] ptr_q, ptr_d;

  // NOTE: every signal written here gets a default before the loop; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin : scan
    int idx;
    int win;
    logic found;
    grant_o = '0;
    found   = 1'b0;
    win     = 0;
    for (int i = 0; i < reqs_p; i++) begin
      idx = (int'(ptr_q) + i) % reqs_p;
      if (!found && cand_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
        win          = idx;
      end
    end
    ptr_d = found ? ptr_w'((win + 1) % reqs_p) : ptr_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vrf_write_arbiter.sv
// Write-port arbiter for the vector register file.
// Several producers each present one full-vector write addressed by global
// register number; each vrf lane grants at most one of them per cycle
// (round-robin per lane) and the granted write is registered onto that lane's
// vrf write port for the next cycle.
// Ports:
//   clk_i, reset_i  : clock, asynchronous active-high reset
//   req_v_i         : per-requester valid
//   req_addr_i      : per-requester global register {lane, local addr}, packed r-major
//   req_data_i      : per-requester vector data, packed r-major
//   req_yumi_o      : request consumed this cycle (combinational)
//   w_addr_o/w_data_o/w_en_o : per-lane vrf write port, packed lane-major
//   conflict_cnt_o  : saturating count of cycles with a valid but ungranted request
module vrf_write_arbiter
  import vrf_pkg::*;
#(
  parameter int els_p   = def_els_p,
  parameter int vlen_p  = def_vlen_p,
  parameter int vdw_p   = def_vdw_p,
  parameter int lanes_p = def_lanes_p,
  parameter int reqs_p  = def_reqs_p,
  localparam int lane_w  = $clog2(lanes_p),
  localparam int laddr_w = $clog2(els_p / lanes_p),
  localparam int gaddr_w = lane_w + laddr_w,
  localparam int data_w  = vlen_p * vdw_p
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [reqs_p-1:0]           req_v_i,
  input  logic [reqs_p*gaddr_w-1:0]   req_addr_i,
  input  logic [reqs_p*data_w-1:0]    req_data_i,
  output logic [reqs_p-1:0]           req_yumi_o,
  output logic [lanes_p*laddr_w-1:0]  w_addr_o,
  output logic [lanes_p*data_w-1:0]   w_data_o,
  output logic [lanes_p-1:0]          w_en_o,
  output logic [15:0]                 conflict_cnt_o
);

  logic [reqs_p-1:0] cand  [lanes_p];
  logic [reqs_p-1:0] grant [lanes_p];

  logic [lanes_p-1:0]         w_en_q,   w_en_d;
  logic [lanes_p*laddr_w-1:0] w_addr_q, w_addr_d;
  logic [lanes_p*data_w-1:0]  w_data_q, w_data_d;
  logic [15:0]                conflict_q, conflict_d;

  // Lane decode. Candidates are masked while reset is high so nothing is
  // consumed that could never be written.
  always_comb begin
    for (int l = 0; l < lanes_p; l++) begin
      for (int r = 0; r < reqs_p; r++) begin
        cand[l][r] = req_v_i[r] && !reset_i &&
                     (req_addr_i[r*gaddr_w + laddr_w +: lane_w] == lane_w'(l));
      end
    end
  end

  for (genvar l = 0; l < lanes_p; l++) begin : g_lane
    vrf_lane_rr_arb #(
      .reqs_p (reqs_p)
    ) u_arb (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .cand_i  (cand[l]),
      .grant_o (grant[l])
    );
  end

  // A requester targets exactly one lane, so at most one lane grants it.
  always_comb begin
    req_yumi_o = '0;
    for (int l = 0; l < lanes_p; l++) req_yumi_o = req_yumi_o | grant[l];
  end

  // Winner mux per lane; addr/data hold when a lane is idle.
  always_comb begin
    w_en_d   = '0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    for (int l = 0; l < lanes_p; l++) begin
      for (int r = 0; r < reqs_p; r++) begin
        if (grant[l][r]) begin
          w_en_d[l]                       = 1'b1;
          w_addr_d[l*laddr_w +: laddr_w]  = req_addr_i[r*gaddr_w +: laddr_w];
          w_data_d[l*data_w +: data_w]    = req_data_i[r*data_w +: data_w];
        end
      end
    end
  end

  always_comb begin
    conflict_d = conflict_q;
    if (($countones(req_v_i) > $countones(req_yumi_o)) && (conflict_q != 16'hFFFF))
      conflict_d = conflict_q + 16'd1;
  end

  // NOTE: the asynchronous reset clears the pending write as well, so a
  // write registered just before reset never reaches the vrf.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      w_en_q     <= '0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      conflict_q <= '0;
    end else begin
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      conflict_q <= conflict_d;
    end
  end

  assign w_en_o         = w_en_q;
  assign w_addr_o       = w_addr_q;
  assign w_data_o       = w_data_q;
  assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Bench for vrf_write_arbiter at default parameters.
// A behavioural model (per-lane priority by round-robin distance, expected
// write-port registers, saturating counter) is compared against the DUT on
// every negative clock edge; directed sequences add literal expectations.
// A shadow vrf built from the DUT write ports checks what actually lands.
module tb_vrf_write_arbiter;
  import vrf_pkg::*;

  localparam int RQ  = def_reqs_p;
  localparam int LN  = def_lanes_p;
  localparam int LW  = def_lane_w;
  localparam int LAW = def_laddr_w;
  localparam int GAW = def_gaddr_w;
  localparam int DW  = def_data_w;
  localparam int EL  = def_els_p;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [RQ-1:0]     req_v;
  logic [RQ*GAW-1:0] req_addr;
  logic [RQ*DW-1:0]  req_data;
  logic [RQ-1:0]     yumi;
  logic [LN*LAW-1:0] w_addr;
  logic [LN*DW-1:0]  w_data;
  logic [LN-1:0]     w_en;
  logic [15:0]       cnt;

  int total = 0;
  int bad   = 0;

  vrf_write_arbiter dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .req_v_i        (req_v),
    .req_addr_i     (req_addr),
    .req_data_i     (req_data),
    .req_yumi_o     (yumi),
    .w_addr_o       (w_addr),
    .w_data_o       (w_data),
    .w_en_o         (w_en),
    .conflict_cnt_o (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int             m_ptr  [LN];
  int             n_ptr  [LN];
  logic [LN-1:0]  m_en,  n_en;
  logic [LAW-1:0] m_addr [LN];
  logic [LAW-1:0] n_addr [LN];
  logic [DW-1:0]  m_data [LN];
  logic [DW-1:0]  n_data [LN];
  int             m_cnt, n_cnt;
  logic [RQ-1:0]  e_y;
  logic [DW-1:0]  shadow [EL];

  task automatic model_clear();
    for (int l = 0; l < LN; l++) begin
      m_ptr[l]  = 0;
      m_addr[l] = '0;
      m_data[l] = '0;
    end
    m_en  = '0;
    m_cnt = 0;
  endtask

  // Winner = valid requester on this lane with the smallest distance
  // (r - ptr) mod RQ; -1 when the lane has no requester.
  function automatic int model_winner(int lane);
    int best  = -1;
    int bestd = RQ;
    int d;
    for (int r = 0; r < RQ; r++) begin
      if (req_v[r] && (int'(req_addr[r*GAW + LAW +: LW]) == lane)) begin
        d = (r - m_ptr[lane] + RQ) % RQ;
        if (d < bestd) begin
          bestd = d;
          best  = r;
        end
      end
    end
    return best;
  endfunction

  always @(negedge clk) begin
    int w;
    if (reset_i) model_clear();
    e_y = '0;
    for (int l = 0; l < LN; l++) begin
      w = reset_i ? -1 : model_winner(l);
      n_en[l]   = (w >= 0);
      n_addr[l] = (w >= 0) ? req_addr[w*GAW +: LAW] : m_addr[l];
      n_data[l] = (w >= 0) ? req_data[w*DW +: DW]   : m_data[l];
      n_ptr[l]  = (w >= 0) ? (w + 1) % RQ : m_ptr[l];
      if (w >= 0) e_y[w] = 1'b1;
    end
    n_cnt = (($countones(req_v) > $countones(e_y)) && (m_cnt < 65535)) ? m_cnt + 1 : m_cnt;

    check("cyc_yumi", 256'(yumi), 256'(e_y));
    check("cyc_w_en", 256'(w_en), 256'(m_en));
    check("cyc_cnt",  256'(cnt),  256'(m_cnt));
    for (int l = 0; l < LN; l++) begin
      check("cyc_w_addr", 256'(w_addr[l*LAW +: LAW]), 256'(m_addr[l]));
      check("cyc_w_data", w_data[l*DW +: DW], m_data[l]);
    end

    // Shadow vrf: the write presented this cycle lands at the coming edge.
    for (int l = 0; l < LN; l++)
      if (w_en[l]) shadow[l*(EL/LN) + int'(w_addr[l*LAW +: LAW])] = w_data[l*DW +: DW];
  end

  always @(posedge clk) begin
    if (reset_i) model_clear();
    else begin
      for (int l = 0; l < LN; l++) begin
        m_ptr[l]  = n_ptr[l];
        m_addr[l] = n_addr[l];
        m_data[l] = n_data[l];
      end
      m_en  = n_en;
      m_cnt = n_cnt;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [GAW-1:0] a, input logic [DW-1:0] d);
    req_v[r]             = 1'b1;
    req_addr[r*GAW +: GAW] = a;
    req_data[r*DW +: DW]   = d;
  endtask

  logic [DW-1:0] da, db, dc, dd, dx;

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    da = {8{32'hA5A5_0001}};
    db = {8{32'hBBBB_0002}};
    dc = {8{32'hCCCC_0003}};
    dd = {8{32'hDDDD_0004}};
    dx = {8{32'h1234_5678}};
    for (int i = 0; i < EL; i++) shadow[i] = '0;
    model_clear();
    reset_i  = 1'b1;
    req_v    = '0;
    req_addr = '0;
    req_data = '0;
    repeat (3) tick();

    // Requests under reset are never consumed.
    set_req(0, 5'd1, dx); set_req(1, 5'd2, dx); set_req(2, 5'd30, dx);
    #1;
    check("rst_yumi", 256'(yumi), 256'(3'b000));
    check("rst_w_en", 256'(w_en), 256'(4'b0000));
    check("rst_cnt",  256'(cnt),  256'(16'd0));
    req_v = '0;
    tick();
    reset_i = 1'b0;
    tick();

    // Single write: r0 -> reg 9 (lane 1, local 1).
    set_req(0, 5'd9, da);
    #1 check("t1_yumi", 256'(yumi), 256'(3'b001));
    tick();
    req_v = '0;
    #1;
    check("t1_w_en",   256'(w_en), 256'(4'b0010));
    check("t1_w_addr", 256'(w_addr[1*LAW +: LAW]), 256'(3'd1));
    check("t1_w_data", w_data[1*DW +: DW], da);
    tick();
    check("t1_vrf", shadow[9], da);

    // All three on lane 2: round-robin order r0, r1, r2.
    set_req(0, 5'd16, dx); set_req(1, 5'd17, db); set_req(2, 5'd18, dc);
    #1 check("t2_y0", 256'(yumi), 256'(3'b001));
    tick(); req_v[0] = 1'b0;
    #1 check("t2_y1", 256'(yumi), 256'(3'b010));
    tick(); req_v[1] = 1'b0;
    #1 check("t2_y2", 256'(yumi), 256'(3'b100));
    tick(); req_v[2] = 1'b0;
    #1 check("t2_cnt", 256'(cnt), 256'(16'd2));

    // Parallel lanes: r0->lane0, r1->lane3, r2->lane0.
    set_req(0, 5'd2, da); set_req(1, 5'd26, db); set_req(2, 5'd5, dc);
    #1 check("t3_y0", 256'(yumi), 256'(3'b011));
    tick(); req_v[0] = 1'b0; req_v[1] = 1'b0;
    #1;
    check("t3_w_en0", 256'(w_en), 256'(4'b1001));
    check("t3_y1",    256'(yumi), 256'(3'b100));
    tick(); req_v[2] = 1'b0;
    #1;
    check("t3_w_en1",  256'(w_en), 256'(4'b0001));
    check("t3_w_addr", 256'(w_addr[0 +: LAW]), 256'(3'd5));
    check("t3_cnt",    256'(cnt), 256'(16'd3));

    // Same register from r1 and r2 with ptr[0]=1: last granted (r2) wins.
    set_req(0, 5'd0, dx);
    tick(); req_v = '0;
    set_req(1, 5'd4, db); set_req(2, 5'd4, dc);
    #1 check("t4_y0", 256'(yumi), 256'(3'b010));
    tick(); req_v[1] = 1'b0;
    #1 check("t4_y1", 256'(yumi), 256'(3'b100));
    tick(); req_v[2] = 1'b0;
    tick();
    check("t4_vrf", shadow[4], dc);

    // Reset while a write to reg 12 is pending: the write is dropped.
    set_req(0, 5'd12, dd);
    #1 check("t6_yumi", 256'(yumi), 256'(3'b001));
    tick(); req_v = '0;
    #1 check("t6_pend", 256'(w_en), 256'(4'b0010));
    reset_i = 1'b1;
    #1;
    check("t6_w_en",   256'(w_en), 256'(4'b0000));
    check("t6_cnt",    256'(cnt),  256'(16'd0));
    check("t6_w_data", w_data[1*DW +: DW], 256'd0);
    tick(); tick();
    reset_i = 1'b0;
    // Lane 3 pointer was 2 before reset; after reset r1 must win over r2.
    set_req(1, 5'd24, da); set_req(2, 5'd25, db);
    #1 check("t6_ptr", 256'(yumi), 256'(3'b010));
    check("t6_lost", shadow[12], 256'd0);
    tick(); req_v[1] = 1'b0;
    tick(); req_v[2] = 1'b0;
    tick();

    // Two requesters held on lane 0 long enough to saturate the counter.
    set_req(0, 5'd1, da); set_req(1, 5'd2, db);
    repeat (65540) tick();
    check("t5_sat", 256'(cnt), 256'(16'hFFFF));
    tick();
    check("t5_hold", 256'(cnt), 256'(16'hFFFF));
    req_v = '0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vrf_write_arbiter.md
# vrf_write_arbiter

Shares the per-lane write ports of the vector register file (`vrf`) between several producers (load unit, vector ALU, matrix unit). Each producer presents one full-vector write request addressed by global register number. The arbiter grants at most one requester per lane per cycle, round-robin per lane, so writes to different lanes proceed in parallel. Granted writes are registered and driven onto the `vrf` write ports one cycle later.

## Interface
- `els_p`, 32, total vector registers; must equal `vrf` `els_p`
- `vlen_p`, 8, elements per vector
- `vdw_p`, 32, bits per element
- `lanes_p`, 4, `vrf` lanes; power of two, divides `els_p`
- `reqs_p`, 3, number of requesters, ≥2
- derived: `lane_w` = clog2(`lanes_p`), `laddr_w` = clog2(`els_p`/`lanes_p`), `gaddr_w` = `lane_w`+`laddr_w`, `data_w` = `vlen_p`*`vdw_p`
- `clk_i` in 1: single clock, rising edge
- `reset_i` in 1: asynchronous, active-high reset
- `req_v_i` in `reqs_p`: request valid per requester
- `req_addr_i` in `reqs_p` x `gaddr_w`: global register number; upper `lane_w` bits = lane, lower `laddr_w` bits = lane-local address
- `req_data_i` in `reqs_p` x `data_w`: vector to write
- `req_yumi_o` out `reqs_p`: request consumed this cycle (combinational from `req_v_i`, `req_addr_i`, and pointer state)
- `w_addr_o` out `lanes_p` x `laddr_w`: to `vrf` `w_addr_i`
- `w_data_o` out `lanes_p` x `data_w`: to `vrf` `w_data_i`
- `w_en_o` out `lanes_p`: to `vrf` `w_en_i`
- `conflict_cnt_o` out 16: saturating count of cycles in which ≥1 valid request was not granted

## Operation
- Requester r targets lane L = `req_addr_i[r]`[msb:`laddr_w`].
- Each lane L has a round-robin pointer `ptr[L]` (clog2(`reqs_p`) bits). Candidates are requesters with `req_v_i` high that target L. The winner is the first candidate found scanning r = `ptr[L]`, `ptr[L]`+1, … modulo `reqs_p`.
- `req_yumi_o[r]`=1 iff r wins its target lane. A requester never receives yumi without valid. Requesters hold valid, addr, and data stable until yumi.
- On a grant at lane L: next-cycle `w_en_o[L]`=1, `w_addr_o[L]` = winner's local addr, `w_data_o[L]` = winner's data. `ptr[L]` is set to (winner+1) mod `reqs_p`.
- With no candidate on lane L: `w_en_o[L]`=0 next cycle. `w_addr_o[L]`/`w_data_o[L]` hold their previous values. `ptr[L]` is unchanged.
- Two requesters writing the same global register in one cycle: only the winner writes. The loser is granted later and overwrites, so last-granted wins.
- `conflict_cnt_o` increments by 1 in any cycle where popcount(`req_v_i`) > popcount(`req_yumi_o`). It saturates at 16'hFFFF.
- Lanes are fully independent. Up to min(`lanes_p`, `reqs_p`) grants can occur per cycle.

## Timing
- Grant decision is combinational in cycle N. The `vrf` write is presented in cycle N+1 and the register updates at the end of cycle N+1. Write latency from yumi to data visible on `vrf` read is 2 edges.
- Reset (async assert, sync deassert by the system): `w_en_o`=0, `w_addr_o`=0, `w_data_o`=0, all `ptr`=0, `conflict_cnt_o`=0. Requests present while `reset_i` is high get `req_yumi_o`=0.
- Reset asserted while a registered write is pending: `w_en_o` drops immediately and the write is lost. Requesters must re-issue.
- No backpressure from `vrf`; every grant completes.

## Structure
- Package `vrf_pkg`: default `els_p`/`vlen_p`/`vdw_p`/`lanes_p` constants and the `lane_w`/`laddr_w`/`gaddr_w` derivations, shared with `vrf`.
- Sub-module `vrf_lane_rr_arb`, instantiated once per lane:
  - inputs: candidate vector (`reqs_p`)
  - outputs: one-hot grant
  - contains the pointer register and its update
- Top level handles: lane decode, grant OR-reduction into `req_yumi_o`, output registers, conflict counter.

## Test plan
- Defaults; r0 writes addr 5'd9 (lane 1, local 1), data A; idle otherwise -> `req_yumi_o`=3'b001 same cycle; next cycle `w_en_o`=4'b0010, `w_addr_o[1]`=1, `w_data_o[1]`=A; `vrf` read of lane 1 addr 1 returns A.
- r0, r1, r2 all target lane 2, held valid for 3 cycles -> grants r0, r1, r2 in order; `conflict_cnt_o` ends at 2.
- r0→lane 0, r1→lane 3, r2→lane 0 same cycle -> yumi 3'b011; `w_en_o`=4'b1001; r2 granted next cycle.
- r1 and r2 both write reg 5'd4 with data B then C, `ptr[0]`=1 -> r1 granted first, r2 next; final `vrf` contents C.
- Hold two requesters on one lane for 65540 cycles -> `conflict_cnt_o` saturates at 16'hFFFF.
- Assert `reset_i` mid-cycle with `w_en_o`=1 -> `w_en_o`=0 immediately; pointers 0; no write lands.
